// File: rtl/alarm_pkg.sv
// Shared encodings, limits and the snooze-target helper for the alarm clock.
package alarm_pkg;

   typedef enum logic [1:0] {
      MODE_RUN       = 2'd0,
      MODE_SET_TIME  = 2'd1,
      MODE_SET_ALARM = 2'd2
   } mode_e;

   typedef enum logic [1:0] {
      AL_IDLE    = 2'd0,
      AL_RINGING = 2'd1,
      AL_SNOOZE  = 2'd2
   } alarm_e;

   localparam logic [5:0] SEC_MAX = 6'd59;
   localparam logic [5:0] MIN_MAX = 6'd59;
   localparam logic [4:0] HR_MAX  = 5'd23;

   typedef struct packed {
      logic [4:0] hr;
      logic [5:0] min;
   } hm_t;

   // hr:min + n minutes (n <= 59), rolling past 23:59 into the next day.
   function automatic hm_t add_minutes(input logic [4:0] hr, input logic [5:0] min,
                                       input logic [5:0] n);
      hm_t        r;
      logic [6:0] sum;
      sum   = {1'b0, min} + {1'b0, n};
      r.hr  = hr;
      r.min = sum[5:0];
      if (sum > {1'b0, MIN_MAX}) begin
         r.min = 6'(sum - 7'd60);
         r.hr  = (hr == HR_MAX) ? 5'd0 : hr + 5'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/hms_counter.sv
// Time-of-day counter. Button increments take priority over the 1 Hz tick and
// never carry; sec_clr pins seconds to zero while the time is being edited.
module hms_counter
   import alarm_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       tick_en,
   input  logic       inc_min,
   input  logic       inc_hr,
   input  logic       sec_clr,
   output logic [4:0] hr,
   output logic [5:0] min,
   output logic [5:0] sec
);

   logic [4:0] hr_q,  hr_d;
   logic [5:0] min_q, min_d;
   logic [5:0] sec_q, sec_d;

   // Next time: increments first, else tick with sec->min->hr carry.
   always_comb begin
      hr_d  = hr_q;
      min_d = min_q;
      sec_d = sec_q;
      if (inc_min || inc_hr) begin
         if (inc_min) min_d = (min_q == MIN_MAX) ? 6'd0 : min_q + 6'd1;
         if (inc_hr)  hr_d  = (hr_q  == HR_MAX)  ? 5'd0 : hr_q  + 5'd1;
      end else if (tick_en) begin
         if (sec_q == SEC_MAX) begin
            sec_d = 6'd0;
            if (min_q == MIN_MAX) begin
               min_d = 6'd0;
               hr_d  = (hr_q == HR_MAX) ? 5'd0 : hr_q + 5'd1;
            end else begin
               min_d = min_q + 6'd1;
            end
         end else begin
            sec_d = sec_q + 6'd1;
         end
      end
      if (sec_clr) sec_d = 6'd0;
   end

   // Time registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         hr_q  <= 5'd0;
         min_q <= 6'd0;
         sec_q <= 6'd0;
      end else begin
         hr_q  <= hr_d;
         min_q <= min_d;
         sec_q <= sec_d;
      end
   end

   assign hr  = hr_q;
   assign min = min_q;
   assign sec = sec_q;

endmodule

// File: rtl/alarm_controller.sv
// Alarm clock controller: mode FSM, alarm setting, alarm/snooze FSM with ring
// timeout, and display select around the hms_counter time base.
//
//   state      | meaning
//   AL_IDLE    | armed or disarmed, silent
//   AL_RINGING | sounding; ring timer counts down on each tick
//   AL_SNOOZE  | silent until time reaches the latched snooze target at :00
module alarm_controller
   import alarm_pkg::*;
#(
   parameter int SNOOZE_MIN   = 5,
   parameter int RING_MAX_SEC = 60
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tick_1hz,
   input  logic       btn_mode,
   input  logic       btn_inc_min,
   input  logic       btn_inc_hr,
   input  logic       btn_snooze,
   input  logic       btn_stop,
   input  logic       alarm_en,
   output logic [4:0] time_hr,
   output logic [5:0] time_min,
   output logic [5:0] time_sec,
   output logic [4:0] disp_hr,
   output logic [5:0] disp_min,
   output logic [1:0] mode,
   output logic       play_sound,
   output logic       snooze_active
);

   localparam logic [5:0] SNOOZE_LEN = 6'(SNOOZE_MIN);
   localparam logic [7:0] RING_LOAD  = 8'(RING_MAX_SEC);

   mode_e      mode_q, mode_d;
   alarm_e     al_q, al_d;
   logic [4:0] alarm_hr_q, alarm_hr_d;
   logic [5:0] alarm_min_q, alarm_min_d;
   logic [7:0] ring_tmr_q, ring_tmr_d;
   hm_t        target_q, target_d;
   logic       ticked_q;
   logic       play_q, snooze_q;

   logic       tick_en, cnt_inc_min, cnt_inc_hr, sec_clr;
   logic [4:0] cur_hr;
   logic [5:0] cur_min, cur_sec;
   logic       at_minute, alarm_hit, snooze_hit;

   // Time only runs outside SET_TIME; edits apply only inside it.
   assign tick_en     = tick_1hz && (mode_q != MODE_SET_TIME);
   assign cnt_inc_min = btn_inc_min && (mode_q == MODE_SET_TIME);
   assign cnt_inc_hr  = btn_inc_hr  && (mode_q == MODE_SET_TIME);
   assign sec_clr     = (mode_d == MODE_SET_TIME);

   hms_counter u_hms (
      .clock   (clock),
      .reset   (reset),
      .tick_en (tick_en),
      .inc_min (cnt_inc_min),
      .inc_hr  (cnt_inc_hr),
      .sec_clr (sec_clr),
      .hr      (cur_hr),
      .min     (cur_min),
      .sec     (cur_sec)
   );

   // Matches are only taken the cycle after a tick moved the time onto :00.
   assign at_minute  = ticked_q && (cur_sec == 6'd0);
   assign alarm_hit  = at_minute && (cur_hr == alarm_hr_q) && (cur_min == alarm_min_q);
   assign snooze_hit = at_minute && (cur_hr == target_q.hr) && (cur_min == target_q.min);

   // Mode cycle and alarm-setting edits.
   always_comb begin
      mode_d      = mode_q;
      alarm_hr_d  = alarm_hr_q;
      alarm_min_d = alarm_min_q;
      if (btn_mode) begin
         case (mode_q)
            MODE_RUN:      mode_d = MODE_SET_TIME;
            MODE_SET_TIME: mode_d = MODE_SET_ALARM;
            default:       mode_d = MODE_RUN;
         endcase
      end
      if (mode_q == MODE_SET_ALARM) begin
         if (btn_inc_min) alarm_min_d = (alarm_min_q == MIN_MAX) ? 6'd0 : alarm_min_q + 6'd1;
         if (btn_inc_hr)  alarm_hr_d  = (alarm_hr_q  == HR_MAX)  ? 5'd0 : alarm_hr_q  + 5'd1;
      end
   end

   // Alarm FSM next state; disarm or leaving RUN overrides everything.
   always_comb begin
      al_d       = al_q;
      ring_tmr_d = ring_tmr_q;
      target_d   = target_q;
      if (!alarm_en || (mode_q != MODE_RUN)) begin
         al_d       = AL_IDLE;
         ring_tmr_d = 8'd0;
      end else begin
         case (al_q)
            AL_IDLE: begin
               if (alarm_hit) begin
                  al_d       = AL_RINGING;
                  ring_tmr_d = RING_LOAD;
               end
            end
            AL_RINGING: begin
               if (btn_stop) begin
                  al_d       = AL_IDLE;
                  ring_tmr_d = 8'd0;
               end else if (btn_snooze) begin
                  al_d       = AL_SNOOZE;
                  ring_tmr_d = 8'd0;
                  target_d   = add_minutes(cur_hr, cur_min, SNOOZE_LEN);
               end else if (tick_1hz) begin
                  if (ring_tmr_q <= 8'd1) begin
                     al_d       = AL_IDLE;
                     ring_tmr_d = 8'd0;
                  end else begin
                     ring_tmr_d = ring_tmr_q - 8'd1;
                  end
               end
            end
            AL_SNOOZE: begin
               if (btn_stop) begin
                  al_d = AL_IDLE;
               end else if (snooze_hit) begin
                  al_d       = AL_RINGING;
                  ring_tmr_d = RING_LOAD;
               end
            end
            default: begin
               al_d       = AL_IDLE;
               ring_tmr_d = 8'd0;
            end
         endcase
      end
   end

   // State, alarm setting and registered outputs.
   always_ff @(posedge clock) begin
      if (!reset) begin
         mode_q      <= MODE_RUN;
         al_q        <= AL_IDLE;
         alarm_hr_q  <= 5'd0;
         alarm_min_q <= 6'd0;
         ring_tmr_q  <= 8'd0;
         target_q    <= '0;
         ticked_q    <= 1'b0;
         play_q      <= 1'b0;
         snooze_q    <= 1'b0;
      end else begin
         mode_q      <= mode_d;
         al_q        <= al_d;
         alarm_hr_q  <= alarm_hr_d;
         alarm_min_q <= alarm_min_d;
         ring_tmr_q  <= ring_tmr_d;
         target_q    <= target_d;
         ticked_q    <= tick_en;
         play_q      <= (al_d == AL_RINGING);
         snooze_q    <= (al_d == AL_SNOOZE);
      end
   end

   assign time_hr       = cur_hr;
   assign time_min      = cur_min;
   assign time_sec      = cur_sec;
   assign disp_hr       = (mode_q == MODE_SET_ALARM) ? alarm_hr_q  : cur_hr;
   assign disp_min      = (mode_q == MODE_SET_ALARM) ? alarm_min_q : cur_min;
   assign mode          = mode_q;
   assign play_sound    = play_q;
   assign snooze_active = snooze_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller with a seconds-of-day reference model.
module tb_alarm_controller;

   localparam int SN   = 5;
   localparam int RMAX = 60;

   localparam bit [5:0] T  = 6'b100000;
   localparam bit [5:0] M  = 6'b010000;
   localparam bit [5:0] IM = 6'b001000;
   localparam bit [5:0] IH = 6'b000100;
   localparam bit [5:0] SZ = 6'b000010;
   localparam bit [5:0] ST = 6'b000001;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       tick_1hz = 1'b0, btn_mode = 1'b0, btn_inc_min = 1'b0, btn_inc_hr = 1'b0;
   logic       btn_snooze = 1'b0, btn_stop = 1'b0, alarm_en = 1'b0;
   logic [4:0] time_hr, disp_hr;
   logic [5:0] time_min, time_sec, disp_min;
   logic [1:0] mode;
   logic       play_sound, snooze_active;

   int total = 0;
   int bad   = 0;
   bit cmp_on = 1'b0;

   always #5 clock = ~clock;

   alarm_controller #(.SNOOZE_MIN(SN), .RING_MAX_SEC(RMAX)) dut (
      .clock         (clock),
      .reset         (reset),
      .tick_1hz      (tick_1hz),
      .btn_mode      (btn_mode),
      .btn_inc_min   (btn_inc_min),
      .btn_inc_hr    (btn_inc_hr),
      .btn_snooze    (btn_snooze),
      .btn_stop      (btn_stop),
      .alarm_en      (alarm_en),
      .time_hr       (time_hr),
      .time_min      (time_min),
      .time_sec      (time_sec),
      .disp_hr       (disp_hr),
      .disp_min      (disp_min),
      .mode          (mode),
      .play_sound    (play_sound),
      .snooze_active (snooze_active)
   );

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int dut_secs();
      return int'(time_hr) * 3600 + int'(time_min) * 60 + int'(time_sec);
   endfunction

   // Reference model: time in seconds of day, alarm in minutes of day,
   // alarm state 0 idle / 1 ringing / 2 snoozing.
   int m_t, m_al, m_mode, m_st, m_left, m_tgt, nst, mh, mm;
   bit m_ticked;

   always @(posedge clock) begin
      if (!reset) begin
         m_t = 0; m_al = 0; m_mode = 0; m_st = 0; m_left = 0; m_tgt = 0; m_ticked = 1'b0;
      end else begin
         nst = m_st;
         if (!alarm_en || m_mode != 0) nst = 0;
         else if (m_st == 0) begin
            if (m_ticked && m_t == m_al * 60) begin nst = 1; m_left = RMAX; end
         end else if (m_st == 1) begin
            if (btn_stop) nst = 0;
            else if (btn_snooze) begin nst = 2; m_tgt = (m_t / 60 + SN) % 1440; end
            else if (tick_1hz) begin m_left--; if (m_left == 0) nst = 0; end
         end else begin
            if (btn_stop) nst = 0;
            else if (m_ticked && m_t == m_tgt * 60) begin nst = 1; m_left = RMAX; end
         end
         m_ticked = tick_1hz && (m_mode != 1);
         if (m_mode == 1) begin
            mh = m_t / 3600; mm = (m_t / 60) % 60;
            if (btn_inc_min) mm = (mm + 1) % 60;
            if (btn_inc_hr)  mh = (mh + 1) % 24;
            m_t = mh * 3600 + mm * 60;
         end else if (tick_1hz) m_t = (m_t + 1) % 86400;
         if (m_mode == 2) begin
            mh = m_al / 60; mm = m_al % 60;
            if (btn_inc_min) mm = (mm + 1) % 60;
            if (btn_inc_hr)  mh = (mh + 1) % 24;
            m_al = mh * 60 + mm;
         end
         if (btn_mode) m_mode = (m_mode + 1) % 3;
         if (m_mode == 1) m_t = m_t - m_t % 60;
         m_st = nst;
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clock) begin
      if (cmp_on) begin
         chk("m_time", dut_secs(), m_t);
         chk("m_mode", int'(mode), m_mode);
         chk("m_disp", int'(disp_hr) * 60 + int'(disp_min), (m_mode == 2) ? m_al : m_t / 60);
         chk("m_play", int'(play_sound), (m_st == 1) ? 1 : 0);
         chk("m_snooze", int'(snooze_active), (m_st == 2) ? 1 : 0);
      end
   end

   task automatic step(input bit [5:0] p);
      {tick_1hz, btn_mode, btn_inc_min, btn_inc_hr, btn_snooze, btn_stop} = p;
      @(posedge clock);
      #1;
      {tick_1hz, btn_mode, btn_inc_min, btn_inc_hr, btn_snooze, btn_stop} = 6'b0;
   endtask

   task automatic rep(input bit [5:0] p, input int n);
      for (int i = 0; i < n; i++) step(p);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         step(T);
         step(6'b0);
      end
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // Reset with pulses present: they must be ignored.
      reset = 1'b0;
      step(T | M | IM | IH);
      cmp_on = 1'b1;
      chk("rst_time", dut_secs(), 0);
      chk("rst_mode", int'(mode), 0);
      chk("rst_play", int'(play_sound), 0);

      // Time 07:29:59, alarm 07:30, back in RUN.
      reset    = 1'b1;
      alarm_en = 1'b1;
      step(M);
      rep(IH, 7);
      rep(IM, 29);
      step(M);
      rep(IH, 7);
      rep(IM, 30);
      ticks(59);
      step(M);
      chk("set_0729", dut_secs(), 7 * 3600 + 29 * 60 + 59);

      // Alarm fires the cycle after the tick reaching 07:30:00.
      step(T);
      chk("t_0730", dut_secs(), 27000);
      chk("ring_lag", int'(play_sound), 0);
      step(6'b0);
      chk("ring_on", int'(play_sound), 1);

      // Snooze 5 minutes: re-ring at 07:35:00.
      step(SZ);
      chk("snz_on", int'(snooze_active), 1);
      ticks(300);
      chk("t_0735", dut_secs(), 27300);
      chk("re_ring", int'(play_sound), 1);

      // Unattended ring stops after exactly 60 ticks.
      ticks(59);
      chk("ring_59", int'(play_sound), 1);
      ticks(1);
      chk("ring_60", int'(play_sound), 0);

      // Alarm 07:37, then stop and snooze together.
      step(M);
      step(M);
      rep(IM, 7);
      step(M);
      ticks(60);
      chk("ring_0737", int'(play_sound), 1);
      step(ST | SZ);
      chk("both_play", int'(play_sound), 0);
      chk("both_snz", int'(snooze_active), 0);

      // SET_TIME 23:59: inc_hr with a simultaneous tick.
      step(M);
      rep(IH, 16);
      rep(IM, 22);
      step(T | IH);
      chk("t_0059", dut_secs(), 59 * 60);

      // Time 23:57:00, alarm 23:58, snooze across midnight.
      rep(IH, 23);
      rep(IM, 58);
      step(M);
      rep(IH, 16);
      rep(IM, 21);
      step(M);
      ticks(60);
      chk("ring_2358", int'(play_sound), 1);
      step(SZ);
      ticks(300);
      chk("t_0003", dut_secs(), 180);
      chk("ring_0003", int'(play_sound), 1);

      // Reset mid-ring.
      reset = 1'b0;
      step(6'b0);
      chk("rr_play", int'(play_sound), 0);
      chk("rr_time", dut_secs(), 0);
      chk("rr_snz", int'(snooze_active), 0);
      reset = 1'b1;
      step(6'b0);
      step(6'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
